instr_loader: RTL and testbench

Boot-time instruction loader sitting directly upstream of the processor's instruction memory and program counter. Receives a byte stream over a valid/ready handshake and packs it into 32-bit big-endian words. Writes each word into instruction memory at consecutive word-aligned byte addresses. Holds the PC disabled until the full image is written, then asserts the PC enable for the rest of run time.

---
 rtl/instr_loader_pkg.sv | 16 +
 rtl/instr_loader_word_assembler.sv | 42 ++++
 rtl/instr_loader.sv | 105 ++++++++++
 tb/tb_instr_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and defaults for the boot-time instruction loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam int unsigned BYTES_PER_WORD     = 4;
  localparam int unsigned WORD_WIDTH         = 8 * BYTES_PER_WORD;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
  localparam int unsigned DEFAULT_WORD_COUNT = 8;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs accepted bytes MSB-first into a word; flags the byte that completes it.
module word_assembler
  import loader_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shiftEnable,
  input  logic [7:0]            byteData,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  wordComplete
);

  localparam int unsigned CW = $clog2(BYTES_PER_WORD);

  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (shiftEnable) begin
      shift_d = {shift_q[WORD_WIDTH-9:0], byteData};
      count_d = count_q + CW'(1);
    end
  end

  // Word as it stands including the incoming byte; valid when wordComplete.
  assign word         = {shift_q[WORD_WIDTH-9:0], byteData};
  assign wordComplete = shiftEnable && (count_q == CW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a byte-streamed image into instruction memory, then releases the PC.
module instr_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned WORD_COUNT = DEFAULT_WORD_COUNT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byteValid,
  input  logic [7:0]            byteData,
  output logic                  byteReady,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memWriteAddress,
  output logic [WORD_WIDTH-1:0] memWriteData,
  output logic                  enablePC,
  output logic                  done
);

  localparam int unsigned    IW        = ADDR_WIDTH - 2;
  localparam logic [IW-1:0]  LAST_WORD = IW'(WORD_COUNT - 1);

  state_e                state_q;
  logic [IW-1:0]         wordIndex_q;
  logic                  byteReady_q;
  logic                  memWriteEnable_q;
  logic [ADDR_WIDTH-1:0] memWriteAddress_q;
  logic [WORD_WIDTH-1:0] memWriteData_q;
  logic                  enablePC_q;
  logic                  done_q;

  logic                  shiftEnable;
  logic [WORD_WIDTH-1:0] asmWord;
  logic                  wordComplete;

  assign shiftEnable = byteValid && byteReady_q;

  word_assembler u_word_assembler (
    .clock        (clock),
    .reset        (reset),
    .clear        (state_q == IDLE),
    .shiftEnable  (shiftEnable),
    .byteData     (byteData),
    .word         (asmWord),
    .wordComplete (wordComplete)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= IDLE;
      wordIndex_q       <= '0;
      byteReady_q       <= 1'b0;
      memWriteEnable_q  <= 1'b0;
      memWriteAddress_q <= '0;
      memWriteData_q    <= '0;
      enablePC_q        <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      memWriteEnable_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          wordIndex_q <= '0;
          if (start) begin
            state_q     <= LOAD;
            byteReady_q <= 1'b1;
          end
        end
        LOAD: begin
          // Address/data are captured with the strobe so they hold afterwards.
          if (wordComplete) begin
            state_q           <= WRITE;
            byteReady_q       <= 1'b0;
            memWriteEnable_q  <= 1'b1;
            memWriteAddress_q <= {wordIndex_q, 2'b00};
            memWriteData_q    <= asmWord;
          end
        end
        WRITE: begin
          if (wordIndex_q == LAST_WORD) begin
            state_q    <= RUN;
            enablePC_q <= 1'b1;
            done_q     <= 1'b1;
          end else begin
            state_q     <= LOAD;
            wordIndex_q <= wordIndex_q + IW'(1);
            byteReady_q <= 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byteReady       = byteReady_q;
  assign memWriteEnable  = memWriteEnable_q;
  assign memWriteAddress = memWriteAddress_q;
  assign memWriteData    = memWriteData_q;
  assign enablePC        = enablePC_q;
  assign done            = done_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a write-strobe scoreboard.
module tb_instr_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        byteValid;
  logic [7:0]  byteData;
  logic        byteReady;
  logic        memWriteEnable;
  logic [4:0]  memWriteAddress;
  logic [31:0] memWriteData;
  logic        enablePC;
  logic        done;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  instr_loader #(.ADDR_WIDTH(5), .WORD_COUNT(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .byteValid       (byteValid),
    .byteData        (byteData),
    .byteReady       (byteReady),
    .memWriteEnable  (memWriteEnable),
    .memWriteAddress (memWriteAddress),
    .memWriteData    (memWriteData),
    .enablePC        (enablePC),
    .done            (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (memWriteEnable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 64'(memWriteEnable), 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(memWriteAddress), 64'(e.addr));
        chk("wr_data", 64'(memWriteData), 64'(e.data));
        chk("ready_in_write", 64'(byteReady), 64'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int unsigned cycles);
    reset = 1'b1; start = 1'b0; byteValid = 1'b0;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap, input bit pulse);
    bit rdy;
    int unsigned n;
    if (gap > 0) begin
      byteValid = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
    byteValid = 1'b1;
    byteData  = b;
    start     = pulse;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 50) begin
      @(negedge clock);
      rdy = (byteReady === 1'b1);
      step();
      start = 1'b0;
      n++;
    end
    if (!rdy) chk("byte_accept_timeout", 64'(byteReady), 64'd1);
  endtask

  task automatic send_word(input int unsigned w, input logic [7:0] base,
                           input int unsigned maxgap, input int pulse_k);
    logic [31:0] wd;
    logic [7:0]  b;
    int unsigned gap;
    wd = '0;
    for (int k = 0; k < 4; k++) begin
      b   = base + 8'(4 * w + k);
      wd  = {wd[23:0], b};
      gap = (maxgap > 0 && k > 0) ? $urandom_range(maxgap, 0) : 0;
      send_byte(b, gap, k == pulse_k);
    end
    exp_q.push_back(wr_t'{addr: 5'(w * 4), data: wd});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byteValid = 1'b0; byteData = '0;

    // Reset state, then byteValid without start must be ignored.
    do_reset(2);
    @(negedge clock);
    chk("rst_byteReady", 64'(byteReady), 64'd0);
    chk("rst_memWriteEnable", 64'(memWriteEnable), 64'd0);
    chk("rst_memWriteAddress", 64'(memWriteAddress), 64'd0);
    chk("rst_memWriteData", 64'(memWriteData), 64'd0);
    chk("rst_enablePC", 64'(enablePC), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    byteValid = 1'b1; byteData = 8'hEE;
    repeat (4) begin
      @(negedge clock);
      chk("idle_ready", 64'(byteReady), 64'd0);
    end
    step();
    byteValid = 1'b0;

    // Full back-to-back load of 0x00..0x1F.
    do_start();
    @(negedge clock);
    chk("ready_after_start", 64'(byteReady), 64'd1);
    step();
    for (int w = 0; w < 8; w++) send_word(w, 8'h00, 0, -1);
    @(negedge clock);
    chk("pc_during_last_write", 64'(enablePC), 64'd0);
    @(negedge clock);
    chk("pc_after_last_write", 64'(enablePC), 64'd1);
    chk("done_after_last_write", 64'(done), 64'd1);
    chk("ready_in_run", 64'(byteReady), 64'd0);
    chk("full_load_writes", 64'(exp_q.size()), 64'd0);

    // Gapped stream plus a spurious start on the sixth byte, then start in RUN.
    do_reset(1);
    @(negedge clock);
    chk("pc_cleared_by_reset", 64'(enablePC), 64'd0);
    step();
    do_start();
    for (int w = 0; w < 8; w++) send_word(w, 8'h00, 3, (w == 1) ? 1 : -1);
    @(negedge clock);
    @(negedge clock);
    chk("gap_pc_on", 64'(enablePC), 64'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clock);
    chk("run_start_pc", 64'(enablePC), 64'd1);
    chk("run_start_done", 64'(done), 64'd1);
    chk("run_start_ready", 64'(byteReady), 64'd0);
    chk("gap_load_writes", 64'(exp_q.size()), 64'd0);

    // Reset two bytes into word 3, then reload with different data.
    do_reset(1);
    do_start();
    for (int w = 0; w < 3; w++) send_word(w, 8'h00, 0, -1);
    send_byte(8'h0C, 0, 1'b0);
    send_byte(8'h0D, 0, 1'b0);
    reset = 1'b1; byteValid = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("midload_rst_addr", 64'(memWriteAddress), 64'd0);
    chk("midload_rst_data", 64'(memWriteData), 64'd0);
    chk("midload_rst_ready", 64'(byteReady), 64'd0);
    chk("midload_rst_we", 64'(memWriteEnable), 64'd0);
    step();
    do_start();
    for (int w = 0; w < 8; w++) send_word(w, 8'h80, 1, -1);
    @(negedge clock);
    @(negedge clock);
    chk("reload_pc_on", 64'(enablePC), 64'd1);
    chk("reload_writes", 64'(exp_q.size()), 64'd0);

    // Reset landing in the WRITE cycle of the last word.
    do_reset(1);
    do_start();
    for (int w = 0; w < 8; w++) send_word(w, 8'h40, 0, -1);
    reset = 1'b1; byteValid = 1'b0;
    step();
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("wrst_pc", 64'(enablePC), 64'd0);
      chk("wrst_done", 64'(done), 64'd0);
      chk("wrst_we", 64'(memWriteEnable), 64'd0);
      chk("wrst_ready", 64'(byteReady), 64'd0);
    end
    chk("wrst_writes", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
